// File: rtl/sweep_pkg.sv
// Shared types and defaults for the sweep sequencer.
package sweep_pkg;

    localparam int unsigned SWEEP_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_cnt.sv
// Loadable N-bit up/down counter; load takes priority over enable.
module sweep_cnt
    import sweep_pkg::*;
#(
    parameter int unsigned N = SWEEP_N_DEFAULT
) (
    input  logic         ck,
    input  logic         rn,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] val,
    output logic [N-1:0] cnt
);

    logic [N-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise step in the requested direction (wraps mod 2^N).
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = val;
        end else if (en) begin
            cnt_d = up ? cnt_q + N'(1) : cnt_q - N'(1);
        end
    end

    // Counter register.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Command-driven sweep sequencer around a loadable up/down counter.
// Optional round-trip (bounce) sweeps are enabled by defining SWEEP_BOUNCE_EN.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned N = SWEEP_N_DEFAULT
) (
    input  logic         ck,
    input  logic         rn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_end,
    input  logic         cmd_up,
`ifdef SWEEP_BOUNCE_EN
    input  logic         cmd_bounce,
`endif
    input  logic         step,
    input  logic         abort,
    output logic [N-1:0] cnt,
    output logic         busy,
    output logic         done
);

    sweep_state_e state_q, state_d;
    logic [N-1:0] start_q, start_d;
    logic [N-1:0] end_q, end_d;
    logic         up_q, up_d;
    logic         bounce_q, bounce_d;
    // Set once the outbound leg of a bounce sweep has reached end.
    logic         leg_q, leg_d;

    logic         bounce_in;
    logic         cnt_load;
    logic         cnt_en;
    logic [N-1:0] cnt_nxt;
    logic [N-1:0] target;

`ifdef SWEEP_BOUNCE_EN
    assign bounce_in = cmd_bounce;
`else
    assign bounce_in = 1'b0;
`endif

    assign cnt_nxt = up_q ? cnt + N'(1) : cnt - N'(1);
    assign target  = leg_q ? start_q : end_q;

    // Next-state and counter control; abort beats step and end detection.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        end_d    = end_q;
        up_d     = up_q;
        bounce_d = bounce_q;
        leg_d    = leg_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    start_d  = cmd_start;
                    end_d    = cmd_end;
                    up_d     = cmd_up;
                    bounce_d = bounce_in;
                    leg_d    = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = (start_q == end_q) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (step) begin
                    cnt_en = 1'b1;
                    if (cnt_nxt == target) begin
                        if (bounce_q && !leg_q) begin
                            leg_d = 1'b1;
                            up_d  = ~up_q;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched command registers.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state_q  <= StIdle;
            start_q  <= '0;
            end_q    <= '0;
            up_q     <= 1'b0;
            bounce_q <= 1'b0;
            leg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            end_q    <= end_d;
            up_q     <= up_d;
            bounce_q <= bounce_d;
            leg_q    <= leg_d;
        end
    end

    sweep_cnt #(
        .N (N)
    ) u_cnt (
        .ck   (ck),
        .rn   (rn),
        .load (cnt_load),
        .en   (cnt_en),
        .up   (up_q),
        .val  (start_q),
        .cnt  (cnt)
    );

    // Status outputs decoded from the state register only.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q == StLoad) || (state_q == StRun);
        done      = (state_q == StDone);
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: expected per-cycle outputs are queued when
// a command is issued and popped one per clock as the DUT advances.
module tb_sweep_ctrl;

    localparam int N = 4;

    logic         ck;
    logic         rn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_start;
    logic [N-1:0] cmd_end;
    logic         cmd_up;
`ifdef SWEEP_BOUNCE_EN
    logic         cmd_bounce;
`endif
    logic         step;
    logic         abort;
    logic [N-1:0] cnt;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [N-1:0] cnt;
        logic         busy;
        logic         done;
        logic         rdy;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         ex;
    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] cur   = '0;

    sweep_ctrl #(
        .N (N)
    ) dut (
        .ck         (ck),
        .rn         (rn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
        .cmd_up     (cmd_up),
`ifdef SWEEP_BOUNCE_EN
        .cmd_bounce (cmd_bounce),
`endif
        .step       (step),
        .abort      (abort),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Expected trace of one plain sweep with step held high: LOAD, counts, DONE, IDLE.
    task automatic push_sweep(input logic [N-1:0] prev, input logic [N-1:0] s,
                              input logic [N-1:0] e, input logic u);
        logic [N-1:0] v;
        v = s;
        exp_q.push_back(exp_t'({prev, 3'b100}));
        while (v != e) begin
            exp_q.push_back(exp_t'({v, 3'b100}));
            v = u ? v + 4'd1 : v - 4'd1;
        end
        exp_q.push_back(exp_t'({v, 3'b010}));
        exp_q.push_back(exp_t'({v, 3'b001}));
    endtask

    // Present a command; waits (bounded) for cmd_ready. Caller's next edge is the handshake.
    task automatic issue(input logic [N-1:0] s, input logic [N-1:0] e, input logic u);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(posedge ck);
            #1;
            w++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_end   = e;
        cmd_up    = u;
    endtask

    task automatic test_reset();
        total++;
        if ({cnt, busy, done, cmd_ready} !== {4'd0, 3'b001}) begin
            bad++;
            $display("FAIL reset_init: got cnt=%0d busy=%b done=%b rdy=%b want 0/0/0/1",
                     cnt, busy, done, cmd_ready);
        end
        @(posedge ck);
        #1;
        rn   = 1'b1;
        step = 1'b1;
        // step in IDLE must not move the counter
        for (int i = 0; i < 2; i++) begin
            @(posedge ck);
            #1;
            total++;
            if ({cnt, busy, done, cmd_ready} !== {4'd0, 3'b001}) begin
                bad++;
                $display("FAIL idle_step[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want 0/0/0/1",
                         i, cnt, busy, done, cmd_ready);
            end
        end
        step = 1'b0;
        issue(4'd3, 4'd10, 1'b1);
        @(posedge ck);
        #1;
        cmd_valid = 1'b0;
        @(posedge ck);
        #1;
        step = 1'b1;
        @(posedge ck);
        #1;
        total++;
        if ({cnt, busy, done, cmd_ready} !== {4'd4, 3'b100}) begin
            bad++;
            $display("FAIL reset_prerun: got cnt=%0d busy=%b done=%b rdy=%b want 4/1/0/0",
                     cnt, busy, done, cmd_ready);
        end
        #2;
        rn = 1'b0;
        #1;
        total++;
        if ({cnt, busy, done, cmd_ready} !== {4'd0, 3'b001}) begin
            bad++;
            $display("FAIL reset_async: got cnt=%0d busy=%b done=%b rdy=%b want 0/0/0/1",
                     cnt, busy, done, cmd_ready);
        end
        #2;
        rn   = 1'b1;
        step = 1'b0;
        @(posedge ck);
        #1;
        total++;
        if ({cnt, busy, done, cmd_ready} !== {4'd0, 3'b001}) begin
            bad++;
            $display("FAIL reset_after: got cnt=%0d busy=%b done=%b rdy=%b want 0/0/0/1",
                     cnt, busy, done, cmd_ready);
        end
        cur = 4'd0;
    endtask

    task automatic test_sweep_up();
        issue(4'd3, 4'd6, 1'b1);
        step = 1'b1;
        push_sweep(cur, 4'd3, 4'd6, 1'b1);
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL sweep_up[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        step = 1'b0;
        cur  = 4'd6;
    endtask

    task automatic test_wrap();
        issue(4'd14, 4'd2, 1'b1);
        step = 1'b1;
        push_sweep(cur, 4'd14, 4'd2, 1'b1);
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL wrap[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        step = 1'b0;
        cur  = 4'd2;
    endtask

    // start==end completes via LOAD->DONE; cmd_valid held high is taken again only once IDLE.
    task automatic test_back_to_back();
        issue(4'd5, 4'd5, 1'b0);
        push_sweep(cur, 4'd5, 4'd5, 1'b0);
        push_sweep(4'd5, 4'd1, 4'd1, 1'b1);
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            if (i == 0) begin
                cmd_start = 4'd1;
                cmd_end   = 4'd1;
                cmd_up    = 1'b1;
            end
            if (i == 3) cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        cmd_valid = 1'b0;
        cur       = 4'd1;
    endtask

    task automatic test_abort();
        logic st[8];
        logic ab[8];
        st = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Down sweep 9->4, step every other cycle, abort+step when cnt=7.
        issue(4'd9, 4'd4, 1'b0);
        exp_q.push_back(exp_t'({cur, 3'b100}));
        exp_q.push_back(exp_t'({4'd9, 3'b100}));
        exp_q.push_back(exp_t'({4'd8, 3'b100}));
        exp_q.push_back(exp_t'({4'd8, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b001}));
        exp_q.push_back(exp_t'({4'd7, 3'b001}));
        for (int i = 0; i < 8; i++) begin
            step  = st[i];
            abort = ab[i];
            @(posedge ck);
            #1;
            cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL abort_run[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        // Abort held from IDLE: ignored there, cancels in LOAD before the load happens.
        step  = 1'b0;
        abort = 1'b1;
        issue(4'd0, 4'd15, 1'b1);
        exp_q.push_back(exp_t'({4'd7, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b001}));
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL abort_load[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        // Abort on the very step that would reach end: no done, count holds.
        abort = 1'b0;
        issue(4'd7, 4'd8, 1'b1);
        step = 1'b1;
        exp_q.push_back(exp_t'({4'd7, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b100}));
        exp_q.push_back(exp_t'({4'd7, 3'b001}));
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            cmd_valid = 1'b0;
            if (i == 1) abort = 1'b1;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL abort_end[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        step  = 1'b0;
        abort = 1'b0;
        cur   = 4'd7;
    endtask

`ifdef SWEEP_BOUNCE_EN
    task automatic test_bounce();
        cmd_bounce = 1'b1;
        issue(4'd2, 4'd4, 1'b1);
        step = 1'b1;
        exp_q.push_back(exp_t'({cur, 3'b100}));
        exp_q.push_back(exp_t'({4'd2, 3'b100}));
        exp_q.push_back(exp_t'({4'd3, 3'b100}));
        exp_q.push_back(exp_t'({4'd4, 3'b100}));
        exp_q.push_back(exp_t'({4'd3, 3'b100}));
        exp_q.push_back(exp_t'({4'd2, 3'b010}));
        exp_q.push_back(exp_t'({4'd2, 3'b001}));
        push_sweep(4'd2, 4'd7, 4'd8, 1'b1);
        for (int i = 0; exp_q.size() != 0; i++) begin
            @(posedge ck);
            #1;
            if (i == 0) begin
                cmd_start  = 4'd7;
                cmd_end    = 4'd8;
                cmd_up     = 1'b1;
                cmd_bounce = 1'b0;
            end
            if (i == 7) cmd_valid = 1'b0;
            ex = exp_q.pop_front();
            total++;
            if ({cnt, busy, done, cmd_ready} !== ex) begin
                bad++;
                $display("FAIL bounce[%0d]: got cnt=%0d busy=%b done=%b rdy=%b want cnt=%0d busy=%b done=%b rdy=%b",
                         i, cnt, busy, done, cmd_ready, ex.cnt, ex.busy, ex.done, ex.rdy);
            end
        end
        cmd_valid = 1'b0;
        step      = 1'b0;
        cur       = 4'd8;
    endtask
`endif

    initial begin
        rn        = 1'b0;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end   = '0;
        cmd_up    = 1'b0;
`ifdef SWEEP_BOUNCE_EN
        cmd_bounce = 1'b0;
`endif
        step      = 1'b0;
        abort     = 1'b0;
        #3;
        test_reset();
        test_sweep_up();
        test_wrap();
        test_back_to_back();
        test_abort();
`ifdef SWEEP_BOUNCE_EN
        test_bounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
